// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage.
// Owns the program counter and keeps exactly one read outstanding to
// instruction memory at a time, so any memory read latency is tolerated.
// The fetched word is held for decode under a valid/ready handshake, and
// the rs1/rs2/rd fields are sliced out for the register bank.
// A branch/jump redirect from the main controller can arrive in any cycle
// and takes priority over every other event.
module instruction_fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0,
    parameter int unsigned          PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,

    // instruction memory read port
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,

    // redirect from the main controller
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    // decode handshake
    input  logic            dec_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,

    output logic [31:0]     fetch_count
);

    // FETCH: issue the request. WAIT: request in flight. HOLD: word offered to decode.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Clears the two byte-offset bits so every address we produce is word aligned.
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic            drop_q;       // response currently in flight belongs to a dead path
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic [31:0]     count_q;

    logic            accept;       // decode takes the held word this cycle
    logic            rsp_kept;     // a response arrives and is for the live path

    assign accept   = (state_q == S_HOLD) && dec_ready && !redirect_valid;
    assign rsp_kept = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect_valid;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values of the others, independent of block ordering.
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect overrides the normal sequencing.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                // The request leaves this cycle even when a redirect is seen.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    // A stale or redirected response just refetches from the current pc.
                    if (redirect_valid || drop_q) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid || dec_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State-decoded outputs: the request pulse and the decode valid.
    always_comb begin
        imem_req  = (state_q == S_FETCH) && !rst;
        out_valid = (state_q == S_HOLD);
    end

    // Program counter: redirect wins, otherwise advance when decode accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & WORD_MASK;
        end else if (accept) begin
            // Wraps naturally modulo 2^XLEN.
            pc_q <= pc_q + XLEN'(PC_STEP);
        end
    end

    // Drop flag: marks the outstanding read as belonging to an abandoned path.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    // The request issued this cycle still carries the old pc.
                    if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        // A response arriving in the redirect cycle is discarded on the
                        // spot, so only an in-flight read needs the flag.
                        drop_q <= !imem_rvalid;
                    end else if (imem_rvalid) begin
                        drop_q <= 1'b0;
                    end
                end
                default: begin
                    drop_q <= drop_q;
                end
            endcase
        end
    end

    // Output holding register: captures a live response, otherwise stays put.
    always_ff @(posedge clk) begin
        // NOTE: only control and the small output register are reset; the held
        // word is cleared too because decode may observe out_instr after reset.
        if (rst) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (rsp_kept) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= pc_q;
        end
    end

    // Accepted-instruction counter; a redirected HOLD word is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign imem_addr   = pc_q & WORD_MASK;
    assign out_instr   = instr_q;
    assign out_pc      = instr_pc_q;
    assign out_rs1     = instr_q[19:15];
    assign out_rs2     = instr_q[24:20];
    assign out_rd      = instr_q[11:7];
    assign fetch_count = count_q;

endmodule
